// File: rtl/cubic_interp_mdl.sv
// Catmull-Rom symbol-timing interpolator for the MSK receiver timing loop.
// A 4-tap delay line feeds a 5-stage Horner pipeline evaluated at fractional offset mu.
module cubic_interp_mdl #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 27,
  parameter int MU_W   = 18
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic                     din_val_i,
  input  logic                     sym_valid_i,
  input  logic [FRAC_W-1:0]        mu_i,
  output logic signed [DATA_W-1:0] dout_o,
  output logic                     dout_val_o,
  output logic                     drop_o
);

  localparam int AW = DATA_W + 4;
  localparam int PW = AW + MU_W + 1;

  localparam logic signed [PW-1:0] HALF_LSB =
    {{(PW-MU_W){1'b0}}, 1'b1, {(MU_W-1){1'b0}}};
  localparam logic signed [AW-1:0] ONE_EXT = {{(AW-1){1'b0}}, 1'b1};
  localparam logic signed [AW-1:0] MAX_EXT = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_EXT = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // (a*mu + half) >>> MU_W; the product is one bit wider than a*mu needs so it never wraps
  function automatic logic signed [AW-1:0] rnd_mul(
    input logic signed [AW-1:0] a,
    input logic [MU_W-1:0]      m
  );
    logic signed [PW-1:0] prod;
    prod    = a * $signed({1'b0, m});
    rnd_mul = AW'((prod + HALF_LSB) >>> MU_W);
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [AW-1:0] v);
    if (v > MAX_EXT) begin
      sat_out = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v < MIN_EXT) begin
      sat_out = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_out = v[DATA_W-1:0];
    end
  endfunction

  logic signed [DATA_W-1:0] x1_r, x2_r, x3_r;
  logic [2:0]               prime_r;
  logic                     accept_s;
  logic [MU_W-1:0]          mu_s;
  logic                     unused_mu_s;

  logic signed [AW-1:0] e0_s, e1_s, e2_s, e3_s;
  logic signed [AW-1:0] d3_s, d2_s, d1_s;

  logic                 s0_v_r, s1_v_r, s2_v_r, s3_v_r;
  logic signed [AW-1:0] s0_d3_r, s0_d2_r, s0_d1_r, s0_c0_r;
  logic [MU_W-1:0]      s0_mu_r, s1_mu_r, s2_mu_r;
  logic signed [AW-1:0] s1_t2_r, s1_d1_r, s1_c0_r;
  logic signed [AW-1:0] s2_t1_r, s2_c0_r;
  logic signed [AW-1:0] s3_u_r, s3_c0_r;
  logic signed [AW-1:0] y_s;

  assign mu_s        = mu_i[FRAC_W-1 -: MU_W];
  assign unused_mu_s = ^mu_i[FRAC_W-MU_W-1:0];
  assign accept_s    = sym_valid_i & din_val_i & (prime_r >= 3'd3);

  // Delay line and priming counter; advance only on accepted samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x1_r    <= {DATA_W{1'b0}};
      x2_r    <= {DATA_W{1'b0}};
      x3_r    <= {DATA_W{1'b0}};
      prime_r <= 3'd0;
    end else if (din_val_i) begin
      x1_r <= din_i;
      x2_r <= x1_r;
      x3_r <= x2_r;
      if (prime_r != 3'd4) begin
        prime_r <= prime_r + 3'd1;
      end
    end
  end

  // Sticky flag: strobe arrived with no sample to interpolate with
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_o <= 1'b0;
    end else if (sym_valid_i && !din_val_i) begin
      drop_o <= 1'b1;
    end
  end

  // Doubled Catmull-Rom coefficients from pre-shift taps plus the incoming sample
  always_comb begin
    e0_s = {{(AW-DATA_W){x3_r[DATA_W-1]}}, x3_r};
    e1_s = {{(AW-DATA_W){x2_r[DATA_W-1]}}, x2_r};
    e2_s = {{(AW-DATA_W){x1_r[DATA_W-1]}}, x1_r};
    e3_s = {{(AW-DATA_W){din_i[DATA_W-1]}}, din_i};
    d3_s = (e3_s - e0_s) + ((e1_s - e2_s) <<< 1) + (e1_s - e2_s);
    d2_s = (e0_s <<< 1) - (e1_s <<< 2) - e1_s + (e2_s <<< 2) - e3_s;
    d1_s = e2_s - e0_s;
  end

  // Stage 0: capture coefficients and mu for an accepted strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_v_r  <= 1'b0;
      s0_d3_r <= {AW{1'b0}};
      s0_d2_r <= {AW{1'b0}};
      s0_d1_r <= {AW{1'b0}};
      s0_c0_r <= {AW{1'b0}};
      s0_mu_r <= {MU_W{1'b0}};
    end else begin
      s0_v_r  <= accept_s;
      s0_d3_r <= d3_s;
      s0_d2_r <= d2_s;
      s0_d1_r <= d1_s;
      s0_c0_r <= e1_s;
      s0_mu_r <= mu_s;
    end
  end

  // Stages 1-3: Horner steps, each carrying its own mu and valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_r  <= 1'b0;
      s1_t2_r <= {AW{1'b0}};
      s1_d1_r <= {AW{1'b0}};
      s1_c0_r <= {AW{1'b0}};
      s1_mu_r <= {MU_W{1'b0}};
      s2_v_r  <= 1'b0;
      s2_t1_r <= {AW{1'b0}};
      s2_c0_r <= {AW{1'b0}};
      s2_mu_r <= {MU_W{1'b0}};
      s3_v_r  <= 1'b0;
      s3_u_r  <= {AW{1'b0}};
      s3_c0_r <= {AW{1'b0}};
    end else begin
      s1_v_r  <= s0_v_r;
      s1_t2_r <= rnd_mul(s0_d3_r, s0_mu_r) + s0_d2_r;
      s1_d1_r <= s0_d1_r;
      s1_c0_r <= s0_c0_r;
      s1_mu_r <= s0_mu_r;
      s2_v_r  <= s1_v_r;
      s2_t1_r <= rnd_mul(s1_t2_r, s1_mu_r) + s1_d1_r;
      s2_c0_r <= s1_c0_r;
      s2_mu_r <= s1_mu_r;
      s3_v_r  <= s2_v_r;
      s3_u_r  <= rnd_mul(s2_t1_r, s2_mu_r);
      s3_c0_r <= s2_c0_r;
    end
  end

  // Undo the coefficient doubling with round-half-up
  assign y_s = s3_c0_r + ((s3_u_r + ONE_EXT) >>> 1);

  // Output register; dout holds between valid pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_o     <= {DATA_W{1'b0}};
      dout_val_o <= 1'b0;
    end else begin
      dout_val_o <= s3_v_r;
      if (s3_v_r) begin
        dout_o <= sat_out(y_s);
      end
    end
  end

endmodule

// File: tb/tb_cubic_interp_mdl.sv
// Self-checking bench for cubic_interp_mdl: directed cases plus randomized traffic
// compared cycle by cycle against a plain-arithmetic reference model.
module tb_cubic_interp_mdl;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [15:0] din_i = 16'sd0;
  logic               din_val_i = 1'b0;
  logic               sym_valid_i = 1'b0;
  logic [26:0]        mu_i = 27'd0;
  logic signed [15:0] dout_o;
  logic               dout_val_o;
  logic               drop_o;

  cubic_interp_mdl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din_i      (din_i),
    .din_val_i  (din_val_i),
    .sym_valid_i(sym_valid_i),
    .mu_i       (mu_i),
    .dout_o     (dout_o),
    .dout_val_o (dout_val_o),
    .drop_o     (drop_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t expq[$];
  int   hist[$];
  int   prime_m = 0;
  int   last_m  = 0;
  bit   drop_m  = 1'b0;

  localparam logic [26:0] MU_HALF = 27'h4000000;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint rr(input longint a, input longint m);
    return (a * m + 64'sd131072) >>> 18;
  endfunction

  // Reference interpolation straight from the coefficient and Horner formulas
  function automatic int ref_interp(input int p0, input int p1, input int p2, input int p3,
                                    input longint m);
    longint d3, d2, d1, t2, t1, u, y;
    d3 = -longint'(p0) + 3 * longint'(p1) - 3 * longint'(p2) + longint'(p3);
    d2 = 2 * longint'(p0) - 5 * longint'(p1) + 4 * longint'(p2) - longint'(p3);
    d1 = longint'(p2) - longint'(p0);
    t2 = rr(d3, m) + d2;
    t1 = rr(t2, m) + d1;
    u  = rr(t1, m);
    y  = longint'(p1) + ((u + 1) >>> 1);
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = (expq.size() > 0) && (expq[0].due == cyc);
    check_eq("dout_val", longint'(dout_val_o), longint'(ev));
    if (ev) begin
      last_m = expq[0].val;
      void'(expq.pop_front());
    end
    check_eq("dout", longint'(dout_o), longint'(last_m));
    check_eq("drop", longint'(drop_o), longint'(drop_m));
  endtask

  // One clock: check this cycle's outputs, then drive inputs and advance the model
  task automatic step(input int d, input bit dv, input bit sv, input logic [26:0] mu);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    din_i       = 16'(d);
    din_val_i   = dv;
    sym_valid_i = sv;
    mu_i        = mu;
    if (sv && !dv) drop_m = 1'b1;
    if (sv && dv && prime_m >= 3) begin
      e.due = cyc + 5;
      e.val = ref_interp(hist[0], hist[1], hist[2], d, longint'(mu >> 9));
      expq.push_back(e);
    end
    if (dv) begin
      hist.push_back(d);
      if (hist.size() > 3) void'(hist.pop_front());
      if (prime_m < 4) prime_m++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1'b0, 1'b0, 27'd0);
  endtask

  task automatic prime3(input int a, input int b, input int c);
    step(a, 1'b1, 1'b0, 27'd0);
    step(b, 1'b1, 1'b0, 27'd0);
    step(c, 1'b1, 1'b0, 27'd0);
  endtask

  task automatic apply_reset(input int hold);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    reset_n     = 1'b0;
    din_i       = 16'sd0;
    din_val_i   = 1'b0;
    sym_valid_i = 1'b0;
    mu_i        = 27'd0;
    expq.delete();
    hist.delete();
    prime_m = 0;
    last_m  = 0;
    drop_m  = 1'b0;
    #1;
    check_eq("rst_dout", longint'(dout_o), 64'sd0);
    check_eq("rst_val", longint'(dout_val_o), 64'sd0);
    check_eq("rst_drop", longint'(drop_o), 64'sd0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
    end
    reset_n = 1'b1;
  endtask

  task automatic strobe_and_check(input string tag, input int p0, input int p1, input int p2,
                                  input int p3, input logic [26:0] mu, input int want);
    prime3(p0, p1, p2);
    step(p3, 1'b1, 1'b1, mu);
    idle(5);
    check_eq({tag, "_val"}, longint'(dout_val_o), 64'sd1);
    check_eq(tag, longint'(dout_o), longint'(want));
  endtask

  initial begin
    apply_reset(3);

    // Constant input: every interpolated sample equals the input level
    for (int i = 0; i < 100; i++) begin
      step(1000, 1'b1, (i % 20) == 19, 27'($urandom));
      if (i >= 24) check_eq("const", longint'(dout_o), 64'sd1000);
    end
    idle(6);

    // Ramp and saturation
    apply_reset(2);
    strobe_and_check("ramp_half", 0, 100, 200, 300, MU_HALF, 150);
    strobe_and_check("ramp_zero", 0, 100, 200, 300, 27'd0, 100);
    strobe_and_check("sat_pos", -32768, 32767, 32767, -32768, MU_HALF, 32767);
    strobe_and_check("sat_neg", 32767, -32768, -32768, 32767, MU_HALF, -32768);

    // Priming: strobe with only two prior samples is ignored silently
    apply_reset(2);
    step(10, 1'b1, 1'b0, 27'd0);
    step(20, 1'b1, 1'b0, 27'd0);
    step(30, 1'b1, 1'b1, MU_HALF);
    idle(6);
    check_eq("prime_drop", longint'(drop_o), 64'sd0);

    // Strobe without a sample: sticky drop
    step(0, 1'b0, 1'b1, MU_HALF);
    idle(1);
    check_eq("drop_set", longint'(drop_o), 64'sd1);
    idle(10);
    check_eq("drop_sticky", longint'(drop_o), 64'sd1);

    // Back-to-back strobes at T and T+1
    apply_reset(2);
    prime3(5, -7, 300);
    step(-40, 1'b1, 1'b1, 27'd12345678);
    step(99, 1'b1, 1'b1, 27'd98765432);
    idle(3);
    check_eq("b2b_t4", longint'(dout_val_o), 64'sd0);
    idle(1);
    check_eq("b2b_t5", longint'(dout_val_o), 64'sd1);
    idle(1);
    check_eq("b2b_t6", longint'(dout_val_o), 64'sd1);
    idle(1);
    check_eq("b2b_t7", longint'(dout_val_o), 64'sd0);

    // Same pair, then reset at T+3 discards both results
    prime3(1, 2, 3);
    step(4, 1'b1, 1'b1, MU_HALF);
    step(5, 1'b1, 1'b1, MU_HALF);
    idle(2);
    apply_reset(2);
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b0, 1'b0, 27'd0);
      check_eq("post_rst_val", longint'(dout_val_o), 64'sd0);
      check_eq("post_rst_dout", longint'(dout_o), 64'sd0);
    end

    // Randomized traffic with gaps, strobes and occasional full-scale samples
    apply_reset(2);
    for (int i = 0; i < 10000; i++) begin
      int  d;
      bit  dv;
      bit  sv;
      d  = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 15) == 0) d = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      dv = ($urandom_range(0, 3) != 0);
      sv = ($urandom_range(0, 4) == 0);
      step(d, dv, sv, 27'($urandom));
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
